// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen
// Frame-buffer read-address generator driven directly by an active-low
// Hsync/Vsync pair. It emits one registered BRAM address per active pixel,
// together with DE_OUT, X and Y. Mirror and flip modes are latched at frame
// start. The line base address is stepped incrementally, so there is no
// multiplier in the pixel path.
module vga_fb_addr_gen #(
  parameter int HSIZE  = 640,
  parameter int VSIZE  = 480,
  parameter int HBP    = 16,
  parameter int VBP    = 20,
  parameter int STRIDE = 640,
  parameter int BASE   = 0,
  parameter int AW     = 19,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          Hsync,
  input  logic          Vsync,
  input  logic          MIRROR_H,
  input  logic          FLIP_V,
  output logic [AW-1:0] ADDR,
  output logic          DE_OUT,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          FRAME_DONE,
  output logic          SHORT_LINE
);

  localparam int PW  = (HBP > 1) ? $clog2(HBP) : 1;
  localparam int VPW = (VBP > 1) ? $clog2(VBP) : 1;
  localparam int LW  = YW + 1;

  localparam logic [XW-1:0]  H_LAST      = XW'(HSIZE - 1);
  localparam logic [YW-1:0]  V_LAST      = YW'(VSIZE - 1);
  localparam logic [LW-1:0]  LINE_LAST   = LW'(VSIZE - 1);
  localparam logic [PW-1:0]  PORCH_LAST  = PW'(HBP - 1);
  localparam logic [VPW-1:0] VPORCH_LAST = VPW'(VBP - 1);
  localparam logic [AW-1:0]  BASE_A      = AW'(BASE);
  localparam logic [AW-1:0]  STRIDE_A    = AW'(STRIDE);
  localparam logic [AW-1:0]  FLIP_BASE   = AW'((VSIZE - 1) * STRIDE);

  typedef enum logic [1:0] {H_SYNC, H_PORCH, H_ACTIVE, H_DONE} h_state_t;
  typedef enum logic [1:0] {V_SYNC, V_PORCH, V_ACTIVE, V_DONE} v_state_t;

  h_state_t h_state, h_next;
  v_state_t v_state, v_next;

  logic [PW-1:0]  pcnt;
  logic [XW-1:0]  xcnt;
  logic [XW-1:0]  x_raw;
  logic [VPW-1:0] vpcnt;
  logic [LW-1:0]  line_cnt;
  logic [AW-1:0]  row_base;
  logic           line_on;
  logic           line_on_now;
  logic           armed;
  logic           mir;
  logic           flp;
  logic           line_start;
  logic           line_end;
  logic           de_next;
  logic           fd_next;
  logic [XW-1:0]  col;
  logic [AW-1:0]  addr_next;
  logic [YW-1:0]  y_next;

  assign line_start = (h_state == H_SYNC) && Hsync;

  // Horizontal state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) h_state <= H_SYNC;
    else          h_state <= h_next;
  end

  // Horizontal next state: sync -> porch -> active run -> wait for next sync
  always_comb begin
    h_next = h_state;
    if (!Hsync) begin
      h_next = H_SYNC;
    end else begin
      case (h_state)
        H_SYNC:   h_next = (HBP == 0) ? H_ACTIVE : H_PORCH;
        H_PORCH:  if (pcnt == PORCH_LAST) h_next = H_ACTIVE;
        H_ACTIVE: if (xcnt == H_LAST) h_next = H_DONE;
        default:  h_next = H_DONE;
      endcase
    end
  end

  // Vertical state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) v_state <= V_SYNC;
    else          v_state <= v_next;
  end

  // Vertical next state: porch and active phases advance on line boundaries
  always_comb begin
    v_next = v_state;
    if (!Vsync) begin
      v_next = V_SYNC;
    end else begin
      case (v_state)
        V_SYNC:   if (armed) v_next = (VBP == 0) ? V_ACTIVE : V_PORCH;
        V_PORCH:  if (line_start && (vpcnt == VPORCH_LAST)) v_next = V_ACTIVE;
        V_ACTIVE: if (line_end && (line_cnt == LINE_LAST)) v_next = V_DONE;
        default:  v_next = V_DONE;
      endcase
    end
  end

  // Pixel-path decode: enable, mirrored column, address and displayed row
  always_comb begin
    x_raw       = (h_state == H_ACTIVE) ? xcnt + XW'(1) : '0;
    line_on_now = line_start ? (v_state == V_ACTIVE) : line_on;
    line_end    = (h_state == H_ACTIVE) && (h_next != H_ACTIVE) && line_on;
    de_next     = (h_next == H_ACTIVE) && line_on_now && Vsync;
    fd_next     = line_end && Vsync && (v_state == V_ACTIVE) && (line_cnt == LINE_LAST);
    col         = mir ? (H_LAST - x_raw) : x_raw;
    addr_next   = BASE_A + row_base + AW'(col);
    y_next      = flp ? (V_LAST - line_cnt[YW-1:0]) : line_cnt[YW-1:0];
  end

  // Porch/pixel counters, per-line active flag and the post-reset Vsync arm
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pcnt    <= '0;
      xcnt    <= '0;
      vpcnt   <= '0;
      line_on <= 1'b0;
      armed   <= 1'b0;
    end else begin
      pcnt <= (h_state == H_PORCH) ? pcnt + PW'(1) : '0;
      xcnt <= x_raw;
      if (v_state != V_PORCH) vpcnt <= '0;
      else if (line_start)    vpcnt <= vpcnt + VPW'(1);
      if (!Vsync) begin
        line_on <= 1'b0;
        armed   <= 1'b1;
      end else if (line_start) begin
        line_on <= (v_state == V_ACTIVE);
      end
    end
  end

  // Frame-level state: mode latch at frame start, incremental row base per line
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mir      <= 1'b0;
      flp      <= 1'b0;
      line_cnt <= '0;
      row_base <= '0;
    end else if (!Vsync) begin
      mir      <= MIRROR_H;
      flp      <= FLIP_V;
      line_cnt <= '0;
      row_base <= FLIP_V ? FLIP_BASE : '0;
    end else if (line_end) begin
      line_cnt <= line_cnt + LW'(1);
      row_base <= flp ? (row_base - STRIDE_A) : (row_base + STRIDE_A);
    end
  end

  // Registered outputs; address and coordinates hold outside active pixels
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ADDR       <= '0;
      DE_OUT     <= 1'b0;
      X          <= '0;
      Y          <= '0;
      FRAME_DONE <= 1'b0;
      SHORT_LINE <= 1'b0;
    end else begin
      DE_OUT     <= de_next;
      FRAME_DONE <= fd_next;
      if (de_next) begin
        ADDR <= addr_next;
        X    <= col;
        Y    <= y_next;
      end
      if ((h_state == H_ACTIVE) && !Hsync) SHORT_LINE <= 1'b1;
    end
  end

endmodule

// File: doc/vga_fb_addr_gen.md
# vga_fb_addr_gen

Parametrised frame-buffer read-address generator for the VGA simulation bench. It derives pixel timing directly from the incoming active-low Hsync/Vsync pair and emits one BRAM read address per active pixel, with a registered data-enable and pixel coordinates. It supports independent horizontal mirror and vertical flip, latched once per frame, plus a configurable base address and line stride. It sits between the sync source and the frame-buffer BRAM read port.

## Interface
- HSIZE, 640: active pixels per line
- VSIZE, 480: active lines per frame
- HBP, 16: clocks from Hsync deassert to first active pixel
- VBP, 20: line starts skipped after Vsync deassert before the first active line
- STRIDE, 640: address increment between lines, STRIDE >= HSIZE
- BASE, 0: frame-buffer base address
- AW, 19: address width; XW, 10: x width; YW, 9: y width
- CLK  in  1  pixel clock, all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- Hsync  in  1  horizontal sync, active low
- Vsync  in  1  vertical sync, active low
- MIRROR_H  in  1  mirror columns, sampled at frame start
- FLIP_V  in  1  flip rows, sampled at frame start
- ADDR  out  AW  BRAM read address, meaningful when DE_OUT=1
- DE_OUT  out  1  active-pixel enable
- X  out  XW  displayed column 0..HSIZE-1
- Y  out  YW  displayed row 0..VSIZE-1
- FRAME_DONE  out  1  one-cycle pulse after the last pixel of line VSIZE-1
- SHORT_LINE  out  1  sticky: Hsync asserted during an active run

## Operation
- Horizontal FSM: H_SYNC (Hsync=0) -> H_PORCH (HBP clocks) -> H_ACTIVE (HSIZE clocks) -> H_DONE (wait for Hsync=0). Hsync=0 in any state forces H_SYNC next cycle. With HBP=0, H_PORCH is skipped.
- Line start: the first edge with Hsync sampled 1 after H_SYNC.
- Vertical FSM: V_SYNC (Vsync=0) -> V_PORCH (VBP line starts) -> V_ACTIVE (VSIZE lines) -> V_DONE (wait for Vsync=0). Vsync=0 forces V_SYNC from any state.
- A line is active only if V_ACTIVE holds at its line start. Lines starting in any other vertical state never assert DE_OUT.
- Frame start is every edge with Vsync sampled 0. On each such edge: latch MIRROR_H and FLIP_V into mir/flp, set the line counter to 0, and set row_base to (VSIZE-1)*STRIDE if FLIP_V else 0.
- Active pixel: col = mir ? HSIZE-1-x : x, where x is the raw pixel index 0..HSIZE-1. ADDR = BASE + row_base + col, modulo 2^AW.
- X = col. Y = flp ? VSIZE-1-line : line.
- End of each active line, whether complete or truncated: row_base moves by -STRIDE if flp, else +STRIDE, and the line counter increments.
- After the line counter reaches VSIZE: enter V_DONE and pulse FRAME_DONE.
- row_base is maintained incrementally; no multiplier in the pixel path. The constant (VSIZE-1)*STRIDE is computed at elaboration.
- SHORT_LINE: set when Hsync=0 is sampled while in H_ACTIVE. It clears only on reset. The truncated line still counts as a line.
- Mode inputs changing mid-frame have no effect until the next frame start.

## Timing
- Reset values: ADDR=0, DE_OUT=0, X=0, Y=0, FRAME_DONE=0, SHORT_LINE=0. Both FSMs in their sync states, mir=flp=0, row_base=0.
- Let E0 be the line-start edge. DE_OUT rises at edge E0+HBP and stays high for exactly HSIZE edges.
- ADDR, X and Y are registered and valid in the same cycles as DE_OUT.
- The first pixel of a line shows col 0 (or HSIZE-1 if mir). Each following pixel steps by +1 (or -1 if mir).
- FRAME_DONE goes high on the edge after the last DE_OUT=1 cycle of the final line, for one cycle.
- Vsync low in mid-line: DE_OUT drops at the next edge; no FRAME_DONE.
- RESET_N low at any time: all outputs return to reset values immediately. The first frame after release begins at the next Vsync=0.

## Test plan
- Normal mode, 640x480, HBP=16, VBP=20:
  - First DE_OUT at E0+16 of the 21st line start after Vsync high.
  - ADDR runs 0..639, then 640..1279 on the next line.
  - Last ADDR is 307199, followed by a FRAME_DONE pulse.
- FLIP_V=1 at frame start: first line ADDR runs 306560..307199; last line runs 0..639; Y runs 479 down to 0.
- MIRROR_H=1 with BASE=0x1000, STRIDE=1024: line 0 ADDR runs 0x127F down to 0x1000; line 1 runs 0x167F down to 0x1400.
- Toggle FLIP_V and MIRROR_H mid-frame: addresses are unchanged until the next Vsync low; the new mode applies from the next frame.
- Hsync low at pixel 100 of a line: DE_OUT drops the next cycle; SHORT_LINE=1 stays set; the next line starts at base+STRIDE.
- Assert RESET_N=0 mid-line, with FLIP_V latched: all outputs are 0 immediately. After release with Vsync high, there is no DE_OUT until a full Vsync pulse.
